// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32IM core (load-use, taken branch, multi-cycle MDU, memory busywait).
// Latency: outputs are combinational from STATE/CNT and inputs, so the pipeline registers act on them at the next edge.
// Backpressure: MEM_BUSYWAIT holds PC, IF/ID and ID/EX and freezes this controller; optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_BUSYWAIT,
    input  logic        IDEX_MEMREAD,
    input  logic [4:0]  IDEX_RD,
    input  logic        IDEX_MDU_OP,
    input  logic [4:0]  IFID_RS1,
    input  logic [4:0]  IFID_RS2,
    input  logic        IFID_USES_RS1,
    input  logic        IFID_USES_RS2,
    input  logic        BRANCH_TAKEN,
    output logic        PC_HOLD,
    output logic        IFID_HOLD,
    output logic        IFID_FLUSH,
    output logic        IDEX_HOLD,
    output logic        IDEX_FLUSH,
    output logic        EXMEM_FLUSH,
    output logic        MDU_BUSY,
    output logic [31:0] STALL_CYCLES,
    output logic [31:0] FLUSH_COUNT
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    // A single-cycle MDU needs no wait state at all.
    localparam logic             MDU_MULTI = (MDU_LATENCY > 1);
    // The entry cycle in RUN is the first occupancy cycle, and the CNT==0 cycle is the last.
    localparam logic [CNT_W-1:0] CNT_INIT  = (MDU_LATENCY > 1) ? CNT_W'(MDU_LATENCY - 2) : '0;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load_use;

    // x0 is hard-wired to zero, so a load targeting it never forms a dependency.
    assign load_use = IDEX_MEMREAD && (IDEX_RD != 5'd0) &&
                      ((IFID_USES_RS1 && (IFID_RS1 == IDEX_RD)) ||
                       (IFID_USES_RS2 && (IFID_RS2 == IDEX_RD)));

    // Priority resolution of hazard sources into pipeline controls and next state.
    always_comb begin
        PC_HOLD     = 1'b0;
        IFID_HOLD   = 1'b0;
        IFID_FLUSH  = 1'b0;
        IDEX_HOLD   = 1'b0;
        IDEX_FLUSH  = 1'b0;
        EXMEM_FLUSH = 1'b0;
        MDU_BUSY    = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;
        if (MEM_BUSYWAIT) begin
            // Whole-pipeline freeze; MDU occupancy status is carried through unchanged.
            PC_HOLD   = 1'b1;
            IFID_HOLD = 1'b1;
            IDEX_HOLD = 1'b1;
            MDU_BUSY  = (state == MDU_WAIT);
        end else begin
            unique case (state)
                RUN: begin
                    if (BRANCH_TAKEN) begin
                        // Squash the two wrong-path instructions; PC takes the target.
                        IFID_FLUSH = 1'b1;
                        IDEX_FLUSH = 1'b1;
                    end else if (MDU_MULTI && IDEX_MDU_OP) begin
                        PC_HOLD     = 1'b1;
                        IFID_HOLD   = 1'b1;
                        IDEX_HOLD   = 1'b1;
                        EXMEM_FLUSH = 1'b1;
                        MDU_BUSY    = 1'b1;
                        state_nxt   = MDU_WAIT;
                        cnt_nxt     = CNT_INIT;
                    end else if (load_use) begin
                        // One bubble into EX; the hazard vanishes once the bubble is there.
                        PC_HOLD    = 1'b1;
                        IFID_HOLD  = 1'b1;
                        IDEX_FLUSH = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (cnt != '0) begin
                        PC_HOLD     = 1'b1;
                        IFID_HOLD   = 1'b1;
                        IDEX_HOLD   = 1'b1;
                        EXMEM_FLUSH = 1'b1;
                        MDU_BUSY    = 1'b1;
                        cnt_nxt     = cnt - CNT_W'(1);
                    end else begin
                        // Result moves to EX/MEM on this edge; a following MDU op restarts in RUN.
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Controller state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Performance counters; busywait stalls are counted as well, wrap modulo 2^32.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (PC_HOLD)    stall_q <= stall_q + 32'd1;
            if (IFID_FLUSH) flush_q <= flush_q + 32'd1;
        end
    end

    assign STALL_CYCLES = stall_q;
    assign FLUSH_COUNT  = flush_q;
`else
    assign STALL_CYCLES = 32'd0;
    assign FLUSH_COUNT  = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32IM core.
- Drives hold/flush controls of PC, IF/ID, ID/EX and EX/MEM from three hazard sources:
  - load-use data hazard,
  - taken branch/jump resolved in EX,
  - multi-cycle M-extension (mul/div) occupancy of EX.
- Memory busywait freezes the whole pipeline and the controller's own state.

Parameters:
- MDU_LATENCY, 4: total cycles a mul/div instruction occupies EX (legal range 1..16).
- CNT_W, 4: width of the internal MDU countdown counter.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- MEM_BUSYWAIT  input  1  instruction or data memory stall.
- IDEX_MEMREAD  input  1  instruction in EX is a load.
- IDEX_RD  input  5  destination register of the instruction in EX.
- IDEX_MDU_OP  input  1  instruction in EX is mul/div/rem.
- IFID_RS1  input  5  rs1 of the instruction in ID.
- IFID_RS2  input  5  rs2 of the instruction in ID.
- IFID_USES_RS1  input  1  ID instruction reads rs1.
- IFID_USES_RS2  input  1  ID instruction reads rs2.
- BRANCH_TAKEN  input  1  EX resolved a taken branch or jump (JAL/JALR).
- PC_HOLD  output  1  PC must not update.
- IFID_HOLD  output  1  IF/ID keeps its contents.
- IFID_FLUSH  output  1  IF/ID loads a NOP.
- IDEX_HOLD  output  1  ID/EX keeps its contents (drives its BUSYWAIT input).
- IDEX_FLUSH  output  1  ID/EX clears (drives its FLUSH input).
- EXMEM_FLUSH  output  1  EX/MEM loads a bubble.
- MDU_BUSY  output  1  EX is occupied by a multi-cycle MDU op.
- STALL_CYCLES  output  32  perf counter (optional feature).
- FLUSH_COUNT  output  32  perf counter (optional feature).

Behaviour:
- State register STATE ∈ {RUN, MDU_WAIT} plus counter CNT[CNT_W-1:0].
- All outputs are combinational from STATE, CNT and inputs. Zero added latency: controls act at the next posedge.
- Reset, asynchronous, may occur mid-operation:
  - STATE=RUN, CNT=0, perf counters=0.
  - Consequently every output reads 0 while RESET is high, provided inputs are idle.
- Priority, evaluated every cycle:
  1. MEM_BUSYWAIT=1:
     - PC_HOLD = IFID_HOLD = IDEX_HOLD = 1; all flush outputs 0.
     - STATE and CNT frozen; MDU_BUSY unchanged.
  2. RUN with BRANCH_TAKEN=1:
     - IFID_FLUSH = IDEX_FLUSH = 1; holds 0 (PC loads the target).
     - A load-use condition in the same cycle is ignored.
  3. RUN with IDEX_MDU_OP=1 and MDU_LATENCY>1:
     - PC_HOLD = IFID_HOLD = IDEX_HOLD = EXMEM_FLUSH = 1; MDU_BUSY=1.
     - Next STATE=MDU_WAIT, CNT<=MDU_LATENCY-2.
  4. RUN with load-use: IDEX_MEMREAD & IDEX_RD!=0 & ((IFID_USES_RS1 & IFID_RS1==IDEX_RD) | (IFID_USES_RS2 & IFID_RS2==IDEX_RD)):
     - PC_HOLD = IFID_HOLD = IDEX_FLUSH = 1 for exactly one cycle (bubble).
     - The condition self-clears once the bubble is in EX.
  5. Otherwise all outputs 0.
- MDU_WAIT, no busywait:
  - CNT!=0: same stall outputs as priority 3; CNT<=CNT-1.
  - CNT==0: all outputs 0, MDU_BUSY=0; STATE<=RUN (result advances to EX/MEM at this edge).
  - BRANCH_TAKEN and load-use are ignored in MDU_WAIT.
- Total EX occupancy of an MDU op is exactly MDU_LATENCY cycles, excluding busywait cycles.
- MDU_LATENCY=1: the controller never leaves RUN; MDU ops cause no stall.
- Back-to-back MDU ops: the second op enters EX on the exit edge and restarts the sequence in RUN. No lost or merged cycles.
- Register x0 never creates a load-use hazard.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - STALL_CYCLES increments once per cycle with PC_HOLD=1.
  - FLUSH_COUNT increments once per cycle with IFID_FLUSH=1.
  - Both are 32-bit, wrap modulo 2^32, cleared by RESET, and frozen-safe (they count busywait stalls too).
- Undefined: both ports tied to 32'd0; no counter flops are synthesised.

Test Plan:
- Load x5 in EX (IDEX_MEMREAD=1, IDEX_RD=5), ID reads rs2=5 (USES_RS2=1) -> one cycle PC_HOLD=IFID_HOLD=IDEX_FLUSH=1, then all 0.
- Same as above with IDEX_RD=0 -> no stall; and with BRANCH_TAKEN=1 simultaneously -> IFID_FLUSH=IDEX_FLUSH=1, PC_HOLD=0.
- MDU_LATENCY=4, IDEX_MDU_OP=1 pulse -> stall outputs and MDU_BUSY high for 3 cycles, low on 4th, STATE back to RUN.
- MDU sequence with MEM_BUSYWAIT=1 for 2 cycles mid-wait -> stall window extends to 5 cycles; CNT does not decrement while busy.
- Assert RESET asynchronously (between clock edges) during MDU_WAIT -> outputs drop immediately, STATE=RUN, next MDU op stalls full 3 cycles.
- With HAZARD_PERF_CNT_EN: 1 load-use bubble + 3 MDU stalls + 2 branch flushes -> STALL_CYCLES=4, FLUSH_COUNT=2; without the macro both read 0.
